multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Multicycle sequencer for the processor's multiply/divide unit. It accepts one-cycle start pulses from the decode stage and iterates a shared WIDTH-bit add/subtract-and-shift datapath, one step per cycle. It reports a fixed-latency result with a ready pulse and an exception flag. It sits beside the single-cycle ALU (add/sub/AND/OR/shift). The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
ctrl_MULT  input  1  one-cycle start pulse for signed multiply
ctrl_DIV  input  1  one-cycle start pulse for signed divide
data_operandA  input  WIDTH  multiplicand / dividend, sampled only on a start cycle
data_operandB  input  WIDTH  multiplier / divisor, sampled only on a start cycle
data_result  output  WIDTH  product low word or quotient
data_exception  output  1  overflow or divide-by-zero; valid with data_resultRDY
data_resultRDY  output  1  one-cycle pulse marking a completed operation
busy  output  1  high while an operation is in flight

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: FSM goes to IDLE. data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0. Reset wins over a same-cycle start. Reset mid-operation aborts the operation with no RDY pulse.
- FSM states: IDLE, MULT, DIV, DONE.
  - IDLE→MULT on ctrl_MULT; IDLE→DIV on ctrl_DIV.
  - MULT/DIV→DONE when the counter reaches WIDTH-1.
  - DONE→IDLE, or directly to MULT/DIV if a start arrives in DONE.
- Start cycle T: latch operands, record operand signs, convert operands to magnitudes, clear counter. busy=1 from T+1.
- Iterations run on cycles T+1..T+WIDTH, one per cycle. The counter increments per iteration.
- Completion: at T+WIDTH+1 (T+33 by default), data_resultRDY=1 for exactly one cycle and busy=0. data_result/data_exception update at that edge and hold until the next completion, a start, or reset.
- Multiply: unsigned shift-add on magnitudes into a 2*WIDTH accumulator, then negate if the signs differ. data_result is the low WIDTH bits. Exception when the signed 2*WIDTH product does not fit in WIDTH signed bits.
- Divide: restoring division on magnitudes. The quotient truncates toward zero. Quotient sign is signA XOR signB. The remainder is discarded.
  - Divisor 0: exception=1, result=0, same fixed latency.
  - MIN_INT / -1: exception=1, result=0x80000000.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins, divide is dropped.
- Start while busy: the in-flight operation is aborted with no RDY pulse. New operands are latched and the counter restarts. busy stays high.
- Operand inputs are ignored outside start cycles.

Decomposition:
- Package multdiv_pkg:
  - state enum (IDLE/MULT/DIV/DONE)
  - WIDTH default
  - MIN_INT constant
  - iteration-count constant
- Sub-module multdiv_counter: CNT_W-bit up-counter with synchronous clear and enable, plus a terminal-count output at WIDTH-1.
- The add/subtract step stays inline.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Multiply: ctrl_MULT at T with A=7, B=-6 → RDY pulse at exactly T+33, result=0xFFFFFFD6 (-42), exception=0; busy high from T+1 to T+32.
- Multiply overflow: A=0x00010000, B=0x00010000 → result=0x00000000, exception=1.
- Divide: A=-7, B=2 → result=0xFFFFFFFD (-3), exception=0. Divide-by-zero: A=5, B=0 → result=0, exception=1, RDY at T+33. MIN_INT/-1 → result=0x80000000, exception=1.
- Restart and priority:
  - ctrl_DIV at T, then ctrl_MULT (A=3, B=4) at T+10 → no RDY at T+33; a single RDY at T+43 with result=12.
  - ctrl_MULT and ctrl_DIV together (A=9, B=3) → result=27.
- Reset mid-op: ctrl_MULT at T, reset at T+5 → no RDY ever, outputs 0. A new ctrl_DIV (A=100, B=7) afterwards returns result=14 after 33 cycles.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and constants for the multiply/divide sequencer
package multdiv_pkg;
   localparam int MD_WIDTH = 32;
   localparam int MD_ITERS = MD_WIDTH;
   localparam logic [MD_WIDTH-1:0] MIN_INT = {1'b1, {(MD_WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
endpackage

// File: rtl/multdiv_counter.sv
// multdiv_counter: iteration counter with synchronous clear/enable and terminal-count flag
module multdiv_counter #(
   parameter int CNT_W = 6,
   parameter int TC    = multdiv_pkg::MD_ITERS - 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + CNT_W'(1);
   end
   assign o_tc = (r_cnt == CNT_W'(TC));
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: multicycle signed multiply/divide sequencer over a shared add/sub-and-shift step
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   state_t r_state, w_state_n;
   logic [WIDTH-1:0] r_hi, r_lo, r_b, r_result;
   logic r_neg, r_exc;
   logic w_start, w_busy, w_mult, w_tc, w_ge, w_dz, w_exc;
   logic [WIDTH-1:0] w_mag_a, w_mag_b, w_hi_n, w_lo_n, w_quo, w_res;
   logic [WIDTH:0] w_add_a, w_add_b, w_sum;
   logic [2*WIDTH-1:0] w_prod, w_sprod;

   multdiv_counter #(.CNT_W(CNT_W), .TC(WIDTH-1)) u_cnt (
      .i_clk(clock), .i_rst(reset), .i_clr(w_start), .i_en(w_busy), .o_tc(w_tc)
   );

   assign w_start = ctrl_MULT | ctrl_DIV;
   assign w_mult  = (r_state == MULT);
   assign w_busy  = (r_state == MULT) || (r_state == DIV);
   assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   // Multiply: {hi,lo} holds partial product over the shifting multiplier.
   // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
   assign w_add_a = w_mult ? {1'b0, r_hi} : {r_hi, r_lo[WIDTH-1]};
   assign w_add_b = {1'b0, (w_mult && !r_lo[0]) ? {WIDTH{1'b0}} : r_b};
   assign w_sum   = w_mult ? w_add_a + w_add_b : w_add_a - w_add_b;
   assign w_ge    = ~w_sum[WIDTH];
   assign w_hi_n  = w_mult ? w_sum[WIDTH:1] : (w_ge ? w_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0]);
   assign w_lo_n  = w_mult ? {w_sum[0], r_lo[WIDTH-1:1]} : {r_lo[WIDTH-2:0], w_ge};

   assign w_prod  = {w_hi_n, w_lo_n};
   assign w_sprod = r_neg ? -w_prod : w_prod;
   assign w_quo   = r_neg ? -w_lo_n : w_lo_n;
   assign w_dz    = (r_b == '0);
   assign w_res   = w_mult ? w_sprod[WIDTH-1:0] : (w_dz ? {WIDTH{1'b0}} : w_quo);
   // A positive quotient with the top bit set only arises from MIN_INT / -1.
   assign w_exc   = w_mult ? (w_sprod[2*WIDTH-1:WIDTH] != {WIDTH{w_sprod[WIDTH-1]}})
                           : (w_dz || (!r_neg && w_lo_n[WIDTH-1]));

   always_comb begin
      w_state_n = r_state;
      w_state_n = ctrl_MULT ? MULT :
                  ctrl_DIV  ? DIV  :
                  w_busy    ? (w_tc ? DONE : r_state) : IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_start) begin
            r_hi  <= '0;
            r_lo  <= ctrl_MULT ? w_mag_b : w_mag_a;
            r_b   <= ctrl_MULT ? w_mag_a : w_mag_b;
            r_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         end else if (w_busy) begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
         end
         if (w_busy && w_tc && !w_start) begin
            r_result <= w_res;
            r_exc    <= w_exc;
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = (r_state == DONE);
   assign busy           = w_busy;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: scoreboard bench comparing the sequencer against signed-arithmetic reference results
module tb_multdiv_ctrl;
   import multdiv_pkg::*;
   logic clock = 1'b0, reset = 1'b0, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0, data_operandB = '0, data_result;
   logic data_exception, data_resultRDY, busy;
   int cyc = 0, checks = 0, failures = 0;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          start;
      int          due;
   } exp_t;
   exp_t q[$];

   multdiv_ctrl dut (
      .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b, input int c);
      exp_t e;
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.start = c;
      e.due = c + 33;
      if (m) begin
         r = sa * sb;
         e.res = r[31:0];
         e.exc = (r != longint'($signed(e.res)));
      end else if (b == 0) begin
         e.res = '0;
         e.exc = 1'b1;
      end else begin
         r = sa / sb;
         e.res = r[31:0];
         e.exc = (r > 64'sd2147483647);
      end
      return e;
   endfunction

   always @(negedge clock) begin
      logic eb;
      eb = 1'b0;
      foreach (q[i]) if (q[i].start < cyc && cyc < q[i].due) eb = 1'b1;
      chk("busy", {31'b0, busy}, {31'b0, eb});
      if (data_resultRDY) begin
         if (q.size() == 0) begin
            chk("spurious_rdy", 32'd1, 32'd0);
         end else begin
            chk("rdy_cycle", cyc, q[0].due);
            chk("result", data_result, q[0].res);
            chk("exception", {31'b0, data_exception}, {31'b0, q[0].exc});
            void'(q.pop_front());
         end
      end
   end

   // Drives one start cycle; any operation still in flight is aborted by it.
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock); #1;
      if (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      if (m || d) q.push_back(model(m, a, b, cyc));
      @(negedge clock); #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(negedge clock); #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("completion_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clock); #1;
      reset = 1'b1;
      @(posedge clock);
      q.delete();
      @(posedge clock);
      @(negedge clock);
      chk("rst_result", data_result, 32'd0);
      chk("rst_exception", {31'b0, data_exception}, 32'd0);
      chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      #1 reset = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return MIN_INT;
         2: return 32'hFFFF_FFFF;
         3: return 32'($signed($urandom_range(0, 200)) - 100);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      issue(1, 0, 7, -6);                       wait_idle();
      issue(1, 0, 32'h0001_0000, 32'h0001_0000); wait_idle();
      issue(0, 1, -7, 2);                       wait_idle();
      issue(0, 1, 5, 0);                        wait_idle();
      issue(0, 1, MIN_INT, -1);                 wait_idle();
      issue(0, 1, 50, 5);
      repeat (8) @(negedge clock);
      issue(1, 0, 3, 4);                        wait_idle();
      issue(1, 1, 9, 3);                        wait_idle();
      issue(1, 0, 123, 456);
      repeat (3) @(negedge clock);
      do_reset();
      repeat (40) @(negedge clock);
      issue(0, 1, 100, 7);                      wait_idle();
      for (int i = 0; i < 60; i++) begin
         logic m, d;
         int gap;
         m = 1'($urandom_range(0, 1));
         d = ~m | 1'($urandom_range(0, 1));
         issue(m, d, pick(), pick());
         gap = $urandom_range(0, 34);
         if ($urandom_range(0, 2) == 0) repeat (gap) @(negedge clock);
         else wait_idle();
      end
      wait_idle();
      repeat (5) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
